instr_fetch_unit: RTL and testbench

Instruction fetch stage for the MIPS core: owns the PC, fetches 32-bit words from instruction memory over a req/ack handshake, and presents the fetched instruction to the controller. The controller returns `pc_src` and `jump`; the block computes the branch and jump targets and selects the next PC. This block is the producer side of the controller's opcode/funct interface and the consumer of its PC-control outputs.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/instr_fetch_unit_next_pc_sel.sv | 29 ++
 rtl/instr_fetch_unit.sv | 83 ++++++++
 tb/tb_instr_fetch_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, primary opcodes, reset PC
// and the branch-offset helper used by the next-PC logic.
package mips_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sign-extend a 16-bit branch immediate and turn the word offset into bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, issue handshake to the
// execute stage, and the controller's opcode/funct and PC-control signals.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic        jump;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_valid, op, funct, pc, pc_plus4,
    input  imem_ack, imem_rdata, instr_ready, pc_src, jump
  );

  // Memory / controller / execute side
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, op, funct, pc, pc_plus4,
    output imem_ack, imem_rdata, instr_ready, pc_src, jump
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC selection: jump target, branch target or sequential PC, with
// jump taking priority over branch.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_instr,     // only the jump index / branch immediate bits matter here
  input  logic        i_pc_src,
  input  logic        i_jump,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;

  // Compute both targets and pick one; arithmetic wraps modulo 2^32.
  always_comb begin
    w_jump_target   = {i_pc_plus4[31:28], i_instr[25:0], 2'b00};
    w_branch_target = i_pc_plus4 + branch_offset(i_instr[15:0]);
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_pc_src) begin
      o_next_pc = w_branch_target;
    end else begin
      o_next_pc = i_pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// a req/ack handshake, holds it for the execute stage and advances the PC
// using the controller's jump/branch decision at issue time.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset_n,
  instr_fetch_unit_if.master ifu_bus
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic         r_imem_req;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_sel u_next_pc_sel (
    .i_pc_plus4 (w_pc_plus4),
    .i_instr    (r_instr[25:0]),
    .i_pc_src   (ifu_bus.pc_src),
    .i_jump     (ifu_bus.jump),
    .o_next_pc  (w_next_pc)
  );

  // Fetch/issue FSM; req is raised one cycle after reset so an ack seen while
  // req is low (including the reset cycle) never captures data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (r_imem_req && ifu_bus.imem_ack) begin
            r_instr       <= ifu_bus.imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= ISSUE;
          end else begin
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
          end
        end
        ISSUE: begin
          if (ifu_bus.instr_ready) begin
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
          end else begin
            r_state       <= ISSUE;
          end
        end
        default: begin
          r_state       <= FETCH;
          r_instr_valid <= 1'b0;
          r_imem_req    <= 1'b0;
        end
      endcase
    end
  end

  assign ifu_bus.imem_req    = r_imem_req;
  assign ifu_bus.imem_addr   = r_pc;
  assign ifu_bus.instr       = r_instr;
  assign ifu_bus.instr_valid = r_instr_valid;
  assign ifu_bus.op          = r_instr[31:26];
  assign ifu_bus.funct       = r_instr[5:0];
  assign ifu_bus.pc          = r_pc;
  assign ifu_bus.pc_plus4    = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fetch-address / instruction
// scoreboard. Instance A starts at PC 0; instance B starts at 0x2000_0040.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] exp_b_q[$];
  logic [31:0] cur_pc;
  int          fetch_cyc;
  int          prev_fetch_cyc;
  int          rel_cyc;

  instr_fetch_unit_if bus_a ();
  instr_fetch_unit_if bus_b ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .ifu_bus (bus_a)
  );

  instr_fetch_unit #(.RESET_PC(32'h2000_0040)) u_dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .ifu_bus (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for a request, check its address, optionally stall, then ack with data.
  task automatic fetch_a(input int stall, input logic [31:0] data);
    logic [31:0] exp;
    int n;
    n = 0;
    while (bus_a.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, bus_a.imem_req}, 32'd1);
    fetch_cyc = cyc;
    exp = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
    check("fetch_addr", bus_a.imem_addr, exp);
    for (int i = 0; i < stall; i++) begin
      bus_a.instr_ready = 1'b1;
      bus_a.pc_src      = 1'b1;
      @(negedge clk);
      check("stall_addr", bus_a.imem_addr, exp);
      check("stall_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    end
    bus_a.instr_ready = 1'b0;
    bus_a.pc_src      = 1'b0;
    bus_a.imem_ack    = 1'b1;
    bus_a.imem_rdata  = data;
    instr_q.push_back(data);
    @(negedge clk);
    bus_a.imem_ack    = 1'b0;
    bus_a.imem_rdata  = 32'hA5A5_0000 | $urandom_range(0, 255);
  endtask

  // Check the issued instruction, hold it for some cycles, then accept it.
  task automatic issue_a(input int hold, input logic src, input logic jmp, input logic [31:0] nxt);
    logic [31:0] w;
    w = (instr_q.size() > 0) ? instr_q.pop_front() : 32'hDEAD_BEEF;
    check("valid", {31'd0, bus_a.instr_valid}, 32'd1);
    check("req_low", {31'd0, bus_a.imem_req}, 32'd0);
    check("instr", bus_a.instr, w);
    check("op", {26'd0, bus_a.op}, {26'd0, w[31:26]});
    check("funct", {26'd0, bus_a.funct}, {26'd0, w[5:0]});
    check("pc", bus_a.pc, cur_pc);
    check("pc_plus4", bus_a.pc_plus4, cur_pc + 32'd4);
    for (int i = 0; i < hold; i++) begin
      bus_a.instr_ready = 1'b0;
      bus_a.pc_src      = ~bus_a.pc_src;
      bus_a.jump        = (i == 1);
      bus_a.imem_ack    = 1'b1;
      bus_a.imem_rdata  = 32'hBAD0_0000 | i;
      @(negedge clk);
      check("hold_instr", bus_a.instr, w);
      check("hold_pc", bus_a.pc, cur_pc);
      check("hold_req", {31'd0, bus_a.imem_req}, 32'd0);
      check("hold_valid", {31'd0, bus_a.instr_valid}, 32'd1);
    end
    bus_a.imem_ack    = 1'b0;
    bus_a.instr_ready = 1'b1;
    bus_a.pc_src      = src;
    bus_a.jump        = jmp;
    exp_addr_q.push_back(nxt);
    cur_pc = nxt;
    @(negedge clk);
    bus_a.instr_ready = 1'b0;
    bus_a.pc_src      = 1'b0;
    bus_a.jump        = 1'b0;
    check("accept_valid", {31'd0, bus_a.instr_valid}, 32'd0);
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.imem_ack = 1'b1;  bus_a.imem_rdata = 32'hFFFF_FFFF;
    bus_a.instr_ready = 1'b0; bus_a.pc_src = 1'b0; bus_a.jump = 1'b0;
    bus_b.imem_ack = 1'b0;  bus_b.imem_rdata = 32'h0000_0000;
    bus_b.instr_ready = 1'b0; bus_b.pc_src = 1'b0; bus_b.jump = 1'b0;
    cur_pc = 32'h0000_0000;
    prev_fetch_cyc = 0;
    repeat (3) @(negedge clk);

    // Reset state, with an ack held high that must be ignored
    check("rst_req", {31'd0, bus_a.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    check("rst_instr", bus_a.instr, 32'h0000_0000);
    check("rst_pc", bus_a.pc, 32'h0000_0000);

    bus_a.imem_ack = 1'b0;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    exp_b_q.push_back(32'h2000_0040);
    rel_cyc = cyc;
    check("release_req", {31'd0, bus_a.imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, bus_a.imem_req}, 32'd1);

    // Zero-wait sequential fetches 0,4,8,C at 2-cycle spacing
    exp_addr_q.push_back(32'h0000_0000);
    fetch_a(0, {OP_ADDI, 5'd1, 5'd2, 16'h0010});
    check("first_valid_lat", cyc - rel_cyc, 32'd2);
    prev_fetch_cyc = fetch_cyc;
    issue_a(0, 1'b0, 1'b0, 32'h0000_0004);
    fetch_a(0, {OP_RTYPE, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20});
    check("spacing_4", fetch_cyc - prev_fetch_cyc, 32'd2);
    prev_fetch_cyc = fetch_cyc;
    issue_a(0, 1'b0, 1'b0, 32'h0000_0008);
    fetch_a(0, {OP_LW, 5'd6, 5'd7, 16'h0004});
    check("spacing_8", fetch_cyc - prev_fetch_cyc, 32'd2);
    prev_fetch_cyc = fetch_cyc;
    issue_a(0, 1'b0, 1'b0, 32'h0000_000C);
    fetch_a(0, {OP_SW, 5'd8, 5'd9, 16'h0008});
    check("spacing_C", fetch_cyc - prev_fetch_cyc, 32'd2);
    issue_a(0, 1'b0, 1'b0, 32'h0000_0010);

    // Branch at 0x10 with offset -2 words -> 0x0C
    fetch_a(0, 32'h1000_FFFE);
    issue_a(0, 1'b1, 1'b0, 32'h0000_000C);

    // Issue held 4 cycles with pc_src toggling, then branch -> 0x08
    fetch_a(0, {OP_BEQ, 5'd0, 5'd0, 16'hFFFE});
    issue_a(4, 1'b1, 1'b0, 32'h0000_0008);

    // Memory stalls 3 cycles on 0x08; branch -4 words -> 0xFFFF_FFFC
    fetch_a(3, {OP_BEQ, 5'd0, 5'd0, 16'hFFFC});
    issue_a(0, 1'b1, 1'b0, 32'hFFFF_FFFC);

    // Sequential from 0xFFFF_FFFC wraps to 0
    fetch_a(0, {OP_J, 26'h3FF_FFFF});
    issue_a(0, 1'b0, 1'b0, 32'h0000_0000);
    fetch_a(0, {OP_ADDI, 5'd0, 5'd1, 16'h0001});
    issue_a(0, 1'b0, 1'b0, 32'h0000_0004);

    // Reset asserted in the same cycle as the ack for 0x04
    check("pre_rst_req", {31'd0, bus_a.imem_req}, 32'd1);
    check("pre_rst_addr", bus_a.imem_addr, exp_addr_q.size() > 0 ? exp_addr_q.pop_front() : 32'hDEAD_BEEF);
    bus_a.imem_ack = 1'b1;
    bus_a.imem_rdata = 32'h1234_5678;
    rst_a_n = 1'b0;
    @(negedge clk);
    bus_a.imem_ack = 1'b0;
    check("mid_rst_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    check("mid_rst_pc", bus_a.pc, 32'h0000_0000);
    check("mid_rst_req", {31'd0, bus_a.imem_req}, 32'd0);
    check("mid_rst_instr", bus_a.instr, 32'h0000_0000);
    rst_a_n = 1'b1;
    @(negedge clk);
    cur_pc = 32'h0000_0000;
    exp_addr_q.push_back(32'h0000_0000);
    fetch_a(0, {OP_RTYPE, 5'd1, 5'd1, 5'd1, 5'd0, 6'h25});
    issue_a(0, 1'b0, 1'b0, 32'h0000_0004);

    // Instance B: jump and branch both asserted, jump wins
    check("b_req", {31'd0, bus_b.imem_req}, 32'd1);
    check("b_addr", bus_b.imem_addr, exp_b_q.size() > 0 ? exp_b_q.pop_front() : 32'hDEAD_BEEF);
    bus_b.imem_ack = 1'b1;
    bus_b.imem_rdata = 32'h0800_0100;
    @(negedge clk);
    bus_b.imem_ack = 1'b0;
    check("b_valid", {31'd0, bus_b.instr_valid}, 32'd1);
    check("b_op", {26'd0, bus_b.op}, {26'd0, OP_J});
    check("b_pc_plus4", bus_b.pc_plus4, 32'h2000_0044);
    bus_b.instr_ready = 1'b1;
    bus_b.jump = 1'b1;
    bus_b.pc_src = 1'b1;
    exp_b_q.push_back(32'h2000_0400);
    @(negedge clk);
    bus_b.instr_ready = 1'b0;
    bus_b.jump = 1'b0;
    bus_b.pc_src = 1'b0;
    check("b_jump_req", {31'd0, bus_b.imem_req}, 32'd1);
    check("b_jump_addr", bus_b.imem_addr, exp_b_q.size() > 0 ? exp_b_q.pop_front() : 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
